// File: rtl/mnist_pkg.sv
// Shared canvas/network constants and types for the MNIST front end.
// Used by the canvas readout sequencer, its pixel mux and the VGA renderer.
package mnist_pkg;

  localparam int CANVAS_DIM = 28;
  localparam int PIX_W      = 16;
  localparam int PIX_MAX    = 2047;
  localparam int N_PIX      = CANVAS_DIM * CANVAS_DIM;
  localparam int IDX_W      = 10;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [CANVAS_DIM-1:0][CANVAS_DIM-1:0] canvas_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    STREAM,
    DONE
  } stream_state_t;

endpackage

// File: rtl/canvas_stream_ctrl_if.sv
// Valid/ready pixel stream from the canvas readout sequencer to the first NN layer.
// The producer owns data/index/last/valid; the consumer owns ready.
interface canvas_stream_ctrl_if
  import mnist_pkg::*;
#(
  parameter int PIX_W = mnist_pkg::PIX_W
);

  logic [PIX_W-1:0] pixData;
  logic [IDX_W-1:0] pixIdx;
  logic             pixValid;
  logic             pixReady;
  logic             pixLast;

  modport master (
    output pixData,
    output pixIdx,
    output pixValid,
    output pixLast,
    input  pixReady
  );

  modport slave (
    input  pixData,
    input  pixIdx,
    input  pixValid,
    input  pixLast,
    output pixReady
  );

endinterface

// File: rtl/canvas_stream_ctrl_pixel_mux.sv
// Combinational canvas cell select with saturation to SAT_MAX.
// Shared with the VGA canvas renderer, so it holds no state.
module canvas_pixel_mux
  import mnist_pkg::*;
#(
  parameter int DIM     = CANVAS_DIM,
  parameter int PIX_W   = mnist_pkg::PIX_W,
  parameter int SAT_MAX = PIX_MAX
) (
  input  logic [DIM-1:0][DIM-1:0][PIX_W-1:0] canvas_i,
  input  logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] x_i,
  input  logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] y_i,
  output logic [PIX_W-1:0] pix_o
);

  localparam logic [PIX_W-1:0] SAT_C = PIX_W'(SAT_MAX);

  logic [PIX_W-1:0] rawPix;

  always_comb begin
    rawPix = canvas_i[x_i][y_i];
    pix_o  = (rawPix > SAT_C) ? SAT_C : rawPix;
  end

endmodule

// File: rtl/canvas_stream_ctrl.sv
// Locks the drawing canvas, lets it settle, then streams all cells row-major
// over valid/ready into the first network layer and pulses done at the end.
module canvas_stream_ctrl
  import mnist_pkg::*;
#(
  parameter int DIM        = CANVAS_DIM,
  parameter int PIX_W      = mnist_pkg::PIX_W,
  parameter int SAT_MAX    = PIX_MAX,
  parameter int SETTLE_CYC = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_i,
  input  logic                               abort_i,
  input  logic [DIM-1:0][DIM-1:0][PIX_W-1:0] canvas_i,
  output logic                               canvasLock_o,
  output logic                               busy_o,
  output logic                               done_o,
  canvas_stream_ctrl_if.master               pixBus
);

  localparam int CW    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CW-1:0]    LAST_C  = CW'(DIM - 1);
  localparam logic [IDX_W-1:0] DIM_IDX = IDX_W'(DIM);
  localparam logic [CNT_W-1:0] CNT_LD  = CNT_W'(SETTLE_CYC - 1);

  stream_state_t    state_q, state_d;
  logic [CNT_W-1:0] settleCnt_q, settleCnt_d;
  logic [CW-1:0]    x_q, x_d;
  logic [CW-1:0]    y_q, y_d;
  logic [PIX_W-1:0] pixData_q, pixData_d;
  logic [IDX_W-1:0] pixIdx_q, pixIdx_d;
  logic             pixValid_q, pixValid_d;
  logic             pixLast_q, pixLast_d;

  logic [CW-1:0]    nextX;
  logic [CW-1:0]    nextY;
  logic [PIX_W-1:0] nextPix;
  logic [IDX_W-1:0] nextIdx;
  logic             nextLast;
  logic             handshake;

  assign handshake = pixValid_q && pixBus.pixReady;

  // Coordinates of the pixel loaded at the next load edge: origin when leaving
  // SETTLE, otherwise the row-major successor of the pixel on the bus.
  always_comb begin
    nextX = '0;
    nextY = '0;
    if (state_q == STREAM) begin
      if (x_q == LAST_C) begin
        nextX = '0;
        nextY = y_q + 1'b1;
      end else begin
        nextX = x_q + 1'b1;
        nextY = y_q;
      end
    end
    nextIdx  = IDX_W'(nextY) * DIM_IDX + IDX_W'(nextX);
    nextLast = (nextX == LAST_C) && (nextY == LAST_C);
  end

  // The canvas is read live at each load edge; the lock held through SETTLE
  // is what guarantees the editor has stopped writing by then.
  canvas_pixel_mux #(
    .DIM     (DIM),
    .PIX_W   (PIX_W),
    .SAT_MAX (SAT_MAX)
  ) uPixelMux (
    .canvas_i (canvas_i),
    .x_i      (nextX),
    .y_i      (nextY),
    .pix_o    (nextPix)
  );

  always_comb begin
    state_d     = state_q;
    settleCnt_d = settleCnt_q;
    x_d         = x_q;
    y_d         = y_q;
    pixData_d   = pixData_q;
    pixIdx_d    = pixIdx_q;
    pixValid_d  = pixValid_q;
    pixLast_d   = pixLast_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = SETTLE;
          settleCnt_d = CNT_LD;
          x_d         = '0;
          y_d         = '0;
        end
      end

      SETTLE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (settleCnt_q == '0) begin
          state_d    = STREAM;
          x_d        = nextX;
          y_d        = nextY;
          pixData_d  = nextPix;
          pixIdx_d   = nextIdx;
          pixLast_d  = nextLast;
          pixValid_d = 1'b1;
        end else begin
          settleCnt_d = settleCnt_q - 1'b1;
        end
      end

      STREAM: begin
        // Abort wins over a same-cycle handshake; the consumer still took that pixel.
        if (abort_i) begin
          state_d    = IDLE;
          pixValid_d = 1'b0;
          pixLast_d  = 1'b0;
        end else if (handshake) begin
          if (pixLast_q) begin
            state_d    = DONE;
            pixValid_d = 1'b0;
            pixLast_d  = 1'b0;
          end else begin
            x_d        = nextX;
            y_d        = nextY;
            pixData_d  = nextPix;
            pixIdx_d   = nextIdx;
            pixLast_d  = nextLast;
            pixValid_d = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      settleCnt_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pixData_q   <= '0;
      pixIdx_q    <= '0;
      pixValid_q  <= 1'b0;
      pixLast_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      settleCnt_q <= settleCnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pixData_q   <= pixData_d;
      pixIdx_q    <= pixIdx_d;
      pixValid_q  <= pixValid_d;
      pixLast_q   <= pixLast_d;
    end
  end

  // Lock covers SETTLE, STREAM and DONE, so it drops on the edge back to IDLE.
  assign busy_o       = (state_q != IDLE);
  assign canvasLock_o = (state_q != IDLE);
  assign done_o       = (state_q == DONE);

  assign pixBus.pixData  = pixData_q;
  assign pixBus.pixIdx   = pixIdx_q;
  assign pixBus.pixValid = pixValid_q;
  assign pixBus.pixLast  = pixLast_q;

endmodule

// File: tb/tb_canvas_stream_ctrl.sv
// Directed bench for canvas_stream_ctrl: a scoreboard queue of expected beats
// is filled per readout and drained by a negedge monitor on the pixel bus.
module tb_canvas_stream_ctrl;
  import mnist_pkg::*;

  localparam int SETTLE_CYC = 4;
  localparam int NPIX       = 784;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    start = 1'b0;
  logic    abort = 1'b0;
  canvas_t canvas;
  logic    lock, busy, done;
  logic    readyLevel = 1'b1;
  logic    randReady = 1'b0;
  logic    randBit = 1'b0;

  int errors = 0;
  int checks = 0;
  int doneCnt = 0;

  logic [26:0] expQ[$];

  canvas_stream_ctrl_if bus ();
  assign bus.pixReady = randReady ? randBit : readyLevel;

  canvas_stream_ctrl #(
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .abort_i      (abort),
    .canvas_i     (canvas),
    .canvasLock_o (lock),
    .busy_o       (busy),
    .done_o       (done),
    .pixBus       (bus.master)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 randBit = ($urandom_range(0, 9) < 3);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] satModel(input logic [15:0] v);
    return (v > 16'd2047) ? 16'd2047 : v;
  endfunction

  function automatic logic [31:0] packOut();
    return {1'b0, lock, busy, done, bus.pixValid, bus.pixLast, bus.pixIdx, bus.pixData};
  endfunction

  task automatic pushFrame();
    for (int i = 0; i < NPIX; i++) begin
      int xi;
      int yi;
      xi = i % 28;
      yi = i / 28;
      expQ.push_back({(i == NPIX - 1), 10'(i), satModel(canvas[xi][yi])});
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges from the one that samples Start until the first valid pixel.
  task automatic measureStart(input string tag);
    int cycles;
    cycles = 0;
    @(posedge clk);
    #1 start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk);
      #1;
      cycles = c;
      if (c == 1) begin
        start = 1'b0;
        checkOutput({tag, "_lockRise"}, {30'd0, lock, busy}, 32'd3);
      end
      if (bus.pixValid) break;
    end
    checkOutput({tag, "_latency"}, cycles, SETTLE_CYC + 1);
  endtask

  task automatic waitDone(input string tag);
    int target;
    target = doneCnt + 1;
    for (int n = 0; n < 8000 && doneCnt < target; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_doneSeen"}, doneCnt, target);
    checkOutput({tag, "_idleAfterDone"}, {29'd0, lock, busy, done}, 32'd0);
    checkOutput({tag, "_queueDrained"}, expQ.size(), 0);
  endtask

  task automatic waitIdx(input int n);
    for (int k = 0; k < 4000; k++) begin
      if (bus.pixValid && bus.pixIdx == 10'(n)) break;
      @(posedge clk);
      #1;
    end
    checkOutput("reachIdx", {22'd0, bus.pixIdx}, n);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pixValid) begin
        checkOutput("beatExpected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          checkOutput("beat", {5'd0, bus.pixLast, bus.pixIdx, bus.pixData}, {5'd0, expQ[0]});
          if (bus.pixReady) void'(expQ.pop_front());
        end
      end
      if (done) begin
        doneCnt++;
        checkOutput("doneAfterLast", expQ.size(), 0);
        checkOutput("lockInDone", {31'd0, lock}, 32'd1);
      end
    end
  end

  initial begin
    int base;
    for (int x = 0; x < 28; x++)
      for (int y = 0; y < 28; y++)
        canvas[x][y] = 16'(y * 28 + x);

    #2;
    checkOutput("resetState", packOut(), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Identity canvas, ready tied high.
    pushFrame();
    measureStart("identity");
    waitDone("identity");
    repeat (5) @(posedge clk);
    #1 checkOutput("identitySingleDone", doneCnt, 1);

    // Saturation boundaries.
    for (int x = 0; x < 28; x++)
      for (int y = 0; y < 28; y++)
        canvas[x][y] = 16'd100;
    canvas[3][0] = 16'd4000;
    canvas[5][1] = 16'd2047;
    canvas[0][2] = 16'd2048;
    pushFrame();
    checkOutput("satModelIdx3", {16'd0, expQ[3][15:0]}, 32'd2047);
    measureStart("sat");
    waitDone("sat");

    // Random canvas with 30% ready duty.
    for (int x = 0; x < 28; x++)
      for (int y = 0; y < 28; y++)
        canvas[x][y] = 16'($urandom_range(0, 65535));
    randReady = 1'b1;
    pushFrame();
    measureStart("stall");
    waitDone("stall");
    randReady = 1'b0;

    // Second Start mid-stream is ignored.
    for (int x = 0; x < 28; x++)
      for (int y = 0; y < 28; y++)
        canvas[x][y] = 16'(y * 28 + x);
    base = doneCnt;
    pushFrame();
    applyStimulus();
    waitIdx(200);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone("restartIgnored");
    repeat (5) @(posedge clk);
    #1 checkOutput("restartSingleDone", doneCnt, base + 1);

    // Abort while stalled at idx 400.
    base = doneCnt;
    pushFrame();
    applyStimulus();
    waitIdx(400);
    readyLevel = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("abortIdle", {28'd0, lock, busy, done, bus.pixValid}, 32'd0);
    expQ.delete();
    readyLevel = 1'b1;
    repeat (4) @(posedge clk);
    #1 checkOutput("abortNoDone", doneCnt, base);
    pushFrame();
    measureStart("afterAbort");
    waitDone("afterAbort");

    // Asynchronous reset in SETTLE.
    base = doneCnt;
    applyStimulus();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("rstInSettle", packOut(), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Asynchronous reset in STREAM.
    pushFrame();
    applyStimulus();
    waitIdx(100);
    #2 rst = 1'b1;
    #1 checkOutput("rstInStream", packOut(), 32'd0);
    expQ.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkOutput("rstNoDone", doneCnt, base);
    pushFrame();
    measureStart("afterReset");
    waitDone("afterReset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/canvas_stream_ctrl.md
Name: canvas_stream_ctrl

Overview:
- Sequences readout of the 28x28 drawing canvas into the MNIST network's input layer.
- On a start pulse it raises a lock so the canvas stops changing, waits a fixed settle interval, then streams all 784 pixels row-major over a valid/ready interface.
- Pulses done after the last pixel is accepted, then releases the lock.
- Sits between the canvas editor (lock gates its Run input at top level) and the first NN layer.

Parameters:
- DIM, 28, canvas width and height in blocks
- PIX_W, 16, canvas cell width in bits
- SAT_MAX, 2047, saturation ceiling applied to each streamed pixel
- SETTLE_CYC, 4, Clk cycles held in SETTLE after lock rises; must be at least 1

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  single-cycle request to begin a readout
- Abort  in  1  synchronous cancel; returns to IDLE
- canvas  in  [PIX_W-1:0] x [DIM-1:0][DIM-1:0]  canvas array, indexed [X][Y]
- canvas_lock  out  1  high from SETTLE through DONE; editor must not write
- pix_data  out  PIX_W  current pixel, min(canvas[x][y], SAT_MAX)
- pix_idx  out  10  linear index y*DIM+x, 0..783
- pix_valid  out  1  pixel presented
- pix_ready  in  1  consumer accepts when valid&&ready
- pix_last  out  1  high with pixel index DIM*DIM-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset values: state=IDLE; x=y=0; canvas_lock=0, pix_valid=0, pix_last=0, busy=0, done=0, pix_data=0, pix_idx=0.
- FSM states: IDLE, SETTLE, STREAM, DONE.
- IDLE:
  - Start=1 -> SETTLE. Settle counter loads SETTLE_CYC-1; canvas_lock=1 from the next edge.
  - Start is ignored in every other state.
- SETTLE:
  - Counter decrements each cycle.
  - At 0 -> STREAM. The first pixel (x=0, y=0) is registered and pix_valid=1 on entry.
- STREAM:
  - Outputs are registered. pix_data, pix_idx, pix_last are stable while pix_valid && !pix_ready.
  - On a handshake, advance x. When x reaches DIM-1, wrap x to 0 and increment y.
  - The next pixel is presented the following cycle, giving 1 pixel/cycle with ready tied high.
  - Handshake with pix_last=1 -> DONE, pix_valid=0.
- DONE:
  - done=1 for exactly this one cycle, then IDLE.
  - canvas_lock drops on the same edge as the IDLE transition.
- Saturation: values > SAT_MAX are output as SAT_MAX; all other values pass unchanged.
- pix_idx is computed with 10-bit arithmetic (y*28+x), max 783.
- Abort:
  - In SETTLE, STREAM or DONE -> IDLE next edge; pix_valid=0, canvas_lock=0, done not pulsed.
  - Abort beats a same-cycle handshake: the pixel counts as accepted by the consumer, but the FSM still goes to IDLE.
  - Abort and Start together in IDLE: Start wins.
- Reset mid-stream: immediate return to reset values (asynchronous); no done pulse.
- Canvas sampling: canvas is sampled combinationally at the pixel-load edge, never snapshotted wholesale. Correctness relies on lock having been held for SETTLE_CYC cycles.
- Latency with pix_ready always 1: Start edge to first valid = SETTLE_CYC+1 cycles; first valid to done = 784 cycles.

Decomposition:
- Package mnist_pkg holds:
  - CANVAS_DIM=28, PIX_W=16, PIX_MAX=2047, N_PIX=784
  - typedef pix_t (logic [15:0])
  - typedef canvas_t (pix_t [27:0][27:0])
  - enum stream_state_t {IDLE, SETTLE, STREAM, DONE}
- One natural sub-module: canvas_pixel_mux.
  - Combinational select canvas[x][y] plus saturation.
  - Shared with the VGA canvas renderer.
- Counters and FSM stay in the top.

Test Plan:
- Reset, then Start with pix_ready=1 and canvas[x][y]=y*28+x -> after SETTLE_CYC+1 cycles, 784 consecutive beats with pix_data==pix_idx; pix_last only at idx 783; done pulses once; canvas_lock falls with the IDLE transition.
- Canvas cell [3][0]=4000, [5][1]=2047 -> idx 3 outputs 2047; idx 33 outputs 2047; all other cells=100 output 100.
- pix_ready random 30% duty -> no lost or duplicated indices; pix_data/pix_idx stable across every stalled cycle; done only after idx 783 is accepted.
- Start pulsed again at idx 200 -> ignored, stream continues to 783, single done.
- Abort at idx 400 mid-stall -> next cycle pix_valid=0, busy=0, canvas_lock=0, no done; new Start restarts at idx 0.
- Reset asserted asynchronously mid-SETTLE and mid-STREAM -> outputs zero immediately; after release, Start gives a full 784-beat stream.
